// File: rtl/delay_timer_arbiter.sv
// delay_timer_arbiter: one shared W-bit tick counter time-multiplexed between
// REQ requesters. A round-robin arbiter picks an owner, loads that owner's
// delay as the count target, counts ticks until the target is reached, and
// then pulses done to the owner for one cycle before re-arbitrating.
module delay_timer_arbiter #(
    parameter int REQ = 4,
    parameter int W   = 6
) (
    input  logic               clk,
    input  logic               reset,
    input  logic               tick,
    input  logic [REQ-1:0]     req,
    input  logic [REQ*W-1:0]   delay,
    output logic [REQ-1:0]     grant,
    output logic [REQ-1:0]     done,
    output logic [W-1:0]       count,
    output logic               busy
);

    localparam int PW = (REQ > 1) ? $clog2(REQ) : 1;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_t;

    state_t         state;
    state_t         state_next;
    logic [REQ-1:0] grant_next;
    logic [REQ-1:0] done_next;
    logic [W-1:0]   count_next;
    logic [W-1:0]   target;
    logic [W-1:0]   target_next;
    logic [PW-1:0]  ptr;
    logic [PW-1:0]  ptr_next;
    logic [PW-1:0]  owner;
    logic [PW-1:0]  owner_next;
    logic [PW-1:0]  winner;
    logic           found;
    logic [W-1:0]   delay_lane [REQ];

    // Split the packed delay bus into one lane per requester.
    always_comb begin
        for (int i = 0; i < REQ; i++) begin
            delay_lane[i] = delay[i*W +: W];
        end
    end

    // Round-robin search: first set request bit at or above the pointer, wrapping.
    always_comb begin
        found  = 1'b0;
        winner = ptr;
        for (int i = 0; i < REQ; i++) begin
            if (!found && req[(int'(ptr) + i) % REQ]) begin
                found  = 1'b1;
                winner = PW'((int'(ptr) + i) % REQ);
            end
        end
    end

    // Next-state and next-output logic; abort outranks completion while running.
    always_comb begin
        state_next  = state;
        grant_next  = grant;
        done_next   = '0;
        count_next  = count;
        target_next = target;
        ptr_next    = ptr;
        owner_next  = owner;
        case (state)
            IDLE: begin
                if (found) begin
                    state_next         = RUN;
                    grant_next         = '0;
                    grant_next[winner] = 1'b1;
                    target_next        = delay_lane[winner];
                    count_next         = '0;
                    owner_next         = winner;
                    ptr_next           = (winner == PW'(REQ - 1)) ? '0 : winner + 1'b1;
                end
            end
            RUN: begin
                if (!req[owner]) begin
                    state_next = IDLE;
                    grant_next = '0;
                    count_next = '0;
                end else if (count == target) begin
                    state_next = DONE;
                    done_next  = grant;
                end else if (tick) begin
                    count_next = count + 1'b1;
                end
            end
            DONE: begin
                state_next = IDLE;
                grant_next = '0;
                count_next = '0;
            end
            default: begin
                state_next = IDLE;
                grant_next = '0;
                count_next = '0;
            end
        endcase
    end

    // State and output registers with synchronous active-low reset.
    always_ff @(posedge clk) begin
        if (!reset) begin
            state  <= IDLE;
            grant  <= '0;
            done   <= '0;
            count  <= '0;
            target <= '0;
            ptr    <= '0;
            owner  <= '0;
        end else begin
            state  <= state_next;
            grant  <= grant_next;
            done   <= done_next;
            count  <= count_next;
            target <= target_next;
            ptr    <= ptr_next;
            owner  <= owner_next;
        end
    end

    assign busy = (state != IDLE);

endmodule
